// File: rtl/rram_forming_ctrl.sv
// RRAM forming controller: scans one block cell by cell, applying forming pulses
// followed by verify reads, retrying up to MAX_TRY times and counting cells that never form.
module rram_forming_ctrl #(
  parameter int PULSE_W  = 4,
  parameter int SETTLE_W = 2,
  parameter int MAX_TRY  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  blk_sel,
  input  logic [4:0]  row_max,
  input  logic [4:0]  col_max,
  input  logic        rram_data,
  output logic [3:0]  block_addr,
  output logic [4:0]  row_addr,
  output logic [4:0]  col_addr,
  output logic        rram_ce,
  output logic        rram_we,
  output logic        rram_re,
  output logic        RB,
  output logic        done,
  output logic [10:0] fail_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_SETTLE, S_VERIFY, S_NEXT, S_DONE
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] cnt;
  logic [3:0]  try_cnt;
  logic [4:0]  row_lim, col_lim;
  logic        last_cell;
  logic        ce_d, we_d, re_d, rb_d, done_d;

  assign last_cell = (row_addr == row_lim) && (col_addr == col_lim);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; abort overrides every busy state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start && !abort) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_PULSE;
      S_PULSE:  if (cnt == 16'(PULSE_W - 1)) state_nxt = S_SETTLE;
      S_SETTLE: if (cnt == 16'(SETTLE_W - 1)) state_nxt = S_VERIFY;
      S_VERIFY: begin
        if (cnt == 16'd1) begin
          if (rram_data)                        state_nxt = S_NEXT;
          else if (try_cnt < 4'(MAX_TRY - 1))   state_nxt = S_PULSE;
          else                                  state_nxt = S_NEXT;
        end
      end
      S_NEXT:   state_nxt = last_cell ? S_DONE : S_SETUP;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort && state != S_IDLE) state_nxt = S_IDLE;
  end

  // Outputs are decoded from the upcoming state so they register in step with it
  always_comb begin
    ce_d   = 1'b0;
    we_d   = 1'b0;
    re_d   = 1'b0;
    rb_d   = 1'b0;
    done_d = 1'b0;
    case (state_nxt)
      S_IDLE:   rb_d = 1'b1;
      S_SETUP:  ce_d = 1'b1;
      S_PULSE:  begin ce_d = 1'b1; we_d = 1'b1; end
      S_SETTLE: ce_d = 1'b1;
      S_VERIFY: begin ce_d = 1'b1; re_d = 1'b1; end
      S_NEXT:   ce_d = 1'b1;
      S_DONE:   done_d = 1'b1;
      default:  rb_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rram_ce <= 1'b0;
      rram_we <= 1'b0;
      rram_re <= 1'b0;
      RB      <= 1'b1;
      done    <= 1'b0;
    end else begin
      rram_ce <= ce_d;
      rram_we <= we_d;
      rram_re <= re_d;
      RB      <= rb_d;
      done    <= done_d;
    end
  end

  // Datapath: phase counter restarts on every state change, address/try/fail bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      try_cnt    <= '0;
      block_addr <= '0;
      row_addr   <= '0;
      col_addr   <= '0;
      row_lim    <= '0;
      col_lim    <= '0;
      fail_cnt   <= '0;
    end else begin
      if (state_nxt != state || state == S_IDLE) cnt <= '0;
      else                                       cnt <= cnt + 16'd1;

      case (state)
        S_IDLE: begin
          if (state_nxt == S_SETUP) begin
            block_addr <= blk_sel;
            row_lim    <= row_max;
            col_lim    <= col_max;
            row_addr   <= '0;
            col_addr   <= '0;
            try_cnt    <= '0;
            fail_cnt   <= '0;
          end
        end
        S_VERIFY: begin
          if (state_nxt == S_PULSE)
            try_cnt <= try_cnt + 4'd1;
          else if (state_nxt == S_NEXT && !rram_data && fail_cnt != 11'd2047)
            fail_cnt <= fail_cnt + 11'd1;
        end
        S_NEXT: begin
          if (state_nxt == S_SETUP) begin
            try_cnt <= '0;
            if (col_addr == col_lim) begin
              col_addr <= '0;
              row_addr <= row_addr + 5'd1;
            end else begin
              col_addr <= col_addr + 5'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rram_forming_ctrl.sv
// Self-checking bench for rram_forming_ctrl: table-driven forming runs with a pulse-address
// scoreboard, plus hand-written abort, start/abort collision and async reset sequences.
module tb_rram_forming_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [3:0]  blk_sel;
  logic [4:0]  row_max;
  logic [4:0]  col_max;
  logic        rram_data;
  logic [3:0]  block_addr;
  logic [4:0]  row_addr;
  logic [4:0]  col_addr;
  logic        rram_ce;
  logic        rram_we;
  logic        rram_re;
  logic        RB;
  logic        done;
  logic [10:0] fail_cnt;

  rram_forming_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .blk_sel(blk_sel), .row_max(row_max), .col_max(col_max), .rram_data(rram_data),
    .block_addr(block_addr), .row_addr(row_addr), .col_addr(col_addr),
    .rram_ce(rram_ce), .rram_we(rram_we), .rram_re(rram_re),
    .RB(RB), .done(done), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] blk;
    logic [4:0] rmax;
    logic [4:0] cmax;
    int         fail_verifies;
    int         pulses_per_cell;
    int         exp_done;
    int         exp_fail;
    bit         poke_start;
  } vec_t;

  vec_t        vecs[4];
  int          assertions = 0;
  int          failures   = 0;
  int          tick = 0;
  int          start_tick = 0;
  int          rcnt = 0;
  int          fail_verifies = 0;
  int          pulses = 0;
  int          dones = 0;
  int          last_done_tick = 0;
  bit          sb_en = 1'b0;
  logic        prev_we = 1'b0;
  logic [13:0] sb_q[$];

  always @(posedge clk) tick <= tick + 1;

  // Array model: a cell reads back formed once more than fail_verifies verifies have completed
  always @(posedge clk) begin
    if (rst || (start && RB)) rcnt <= 0;
    else if (rram_re)         rcnt <= rcnt + 1;
  end
  assign rram_data = (rcnt > 2 * fail_verifies);

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Pulse-address scoreboard and strobe legality monitor
  always @(negedge clk) begin
    logic [13:0] exp_addr;
    if (rram_we && !prev_we) begin
      pulses++;
      if (sb_en) begin
        if (sb_q.size() == 0) begin
          check_output("sb_extra_pulse", 32'(sb_q.size()), 32'd1);
        end else begin
          exp_addr = sb_q.pop_front();
          check_output("sb_pulse_addr", 32'({block_addr, row_addr, col_addr}), 32'(exp_addr));
        end
      end
    end
    prev_we = rram_we;
    if (done) begin
      dones++;
      last_done_tick = tick;
    end
    check_output("strobe_rule",
                 32'(!(rram_we && rram_re) && (rram_ce || !(rram_we || rram_re))), 32'd1);
  end

  task automatic apply_stimulus();
    @(negedge clk);
    start      = 1'b1;
    start_tick = tick + 1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic check_reset_values(string name);
    check_output(name,
      32'({block_addr, row_addr, col_addr, rram_ce, rram_we, rram_re, RB, done, fail_cnt}),
      32'({4'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd0}));
  endtask

  task automatic run_vec(vec_t v);
    int n;
    int p0;
    int d0;
    int cells;
    sb_q.delete();
    for (int r = 0; r <= int'(v.rmax); r++)
      for (int c = 0; c <= int'(v.cmax); c++)
        for (int p = 0; p < v.pulses_per_cell; p++)
          sb_q.push_back({v.blk, 5'(r), 5'(c)});
    cells         = (int'(v.rmax) + 1) * (int'(v.cmax) + 1);
    fail_verifies = v.fail_verifies;
    blk_sel       = v.blk;
    row_max       = v.rmax;
    col_max       = v.cmax;
    sb_en         = 1'b1;
    p0            = pulses;
    d0            = dones;
    apply_stimulus();
    n = 0;
    while (RB == 1'b0 && n < 20000) begin
      @(negedge clk);
      n++;
      if (v.poke_start) start = ((tick - start_tick + 1) == 500);
    end
    start = 1'b0;
    sb_en = 1'b0;
    check_output("run_timeout", 32'(n < 20000), 32'd1);
    check_output("rb_cycle", 32'(tick - start_tick + 1), 32'(v.exp_done + 1));
    check_output("done_cycle", 32'(last_done_tick - start_tick + 1), 32'(v.exp_done));
    check_output("done_count", 32'(dones - d0), 32'd1);
    check_output("fail_cnt", 32'(fail_cnt), 32'(v.exp_fail));
    check_output("final_addr", 32'({block_addr, row_addr, col_addr}),
                 32'({v.blk, v.rmax, v.cmax}));
    check_output("pulse_count", 32'(pulses - p0), 32'(cells * v.pulses_per_cell));
    check_output("sb_leftover", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int n;
    int d0;
    vecs[0] = '{blk: 4'd3,  rmax: 5'd0,  cmax: 5'd1,  fail_verifies: 0,   pulses_per_cell: 1,
                exp_done: 21,    exp_fail: 0, poke_start: 1'b0};
    vecs[1] = '{blk: 4'd5,  rmax: 5'd0,  cmax: 5'd0,  fail_verifies: 2,   pulses_per_cell: 3,
                exp_done: 27,    exp_fail: 0, poke_start: 1'b0};
    vecs[2] = '{blk: 4'd10, rmax: 5'd1,  cmax: 5'd1,  fail_verifies: 255, pulses_per_cell: 3,
                exp_done: 105,   exp_fail: 4, poke_start: 1'b0};
    vecs[3] = '{blk: 4'd15, rmax: 5'd31, cmax: 5'd31, fail_verifies: 0,   pulses_per_cell: 1,
                exp_done: 10241, exp_fail: 0, poke_start: 1'b1};

    rst     = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    blk_sel = 4'd0;
    row_max = 5'd0;
    col_max = 5'd0;
    #12;
    check_reset_values("reset_state");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset_values("idle_after_reset");

    for (int i = 0; i < 4; i++) begin
      $display("[TB] vector %0d: rows 0..%0d cols 0..%0d", i, vecs[i].rmax, vecs[i].cmax);
      run_vec(vecs[i]);
      repeat (3) @(negedge clk);
    end

    // Abort in the 2nd pulse cycle of cell (0,1); cell (0,0) has already failed
    fail_verifies = 255;
    blk_sel = 4'd2;
    row_max = 5'd0;
    col_max = 5'd1;
    d0 = dones;
    apply_stimulus();
    n = 0;
    while (!(rram_we && col_addr == 5'd1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("abort_reach_pulse", 32'(n < 200), 32'd1);
    @(negedge clk);
    check_output("abort_pulse2_we", 32'(rram_we), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_output("abort_strobes", 32'({rram_ce, rram_we, rram_re, RB}), 32'(4'b0001));
    check_output("abort_fail_hold", 32'(fail_cnt), 32'd1);
    repeat (5) @(negedge clk);
    check_output("abort_no_done", 32'(dones - d0), 32'd0);
    check_output("abort_stays_idle", 32'({RB, rram_ce}), 32'(2'b10));

    // start and abort together in IDLE: abort wins, fail_cnt not cleared
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_output("start_abort_idle", 32'({RB, rram_ce}), 32'(2'b10));
    @(negedge clk);
    check_output("start_abort_fail_hold", 32'(fail_cnt), 32'd1);

    // Asynchronous reset in the middle of SETTLE
    fail_verifies = 0;
    blk_sel = 4'd7;
    row_max = 5'd0;
    col_max = 5'd0;
    d0 = dones;
    apply_stimulus();
    n = 0;
    while (!rram_we && n < 50) begin @(negedge clk); n++; end
    while (rram_we && n < 50)  begin @(negedge clk); n++; end
    check_output("settle_reached",
                 32'({n < 50, rram_ce, rram_we, rram_re}), 32'(4'b1100));
    #2 rst = 1'b1;
    #1 check_reset_values("async_reset_mid_settle");
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check_output("reset_no_done", 32'(dones - d0), 32'd0);
    check_output("reset_idle_after", 32'({RB, rram_ce, fail_cnt}), 32'({1'b1, 1'b0, 11'd0}));

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/rram_forming_ctrl.md
RRAM_FORMING_CTRL -- requirements
Module: rram_forming_ctrl

Interface
REQ-001 Parameter PULSE_W, default 4: rram_we high time per forming pulse, in clk cycles (>=1).
REQ-002 Parameter SETTLE_W, default 2: idle cycles between a pulse and its verify read (>=1).
REQ-003 Parameter MAX_TRY, default 3: maximum forming pulses per cell (1..15).
REQ-004 Port list, one per line:
- clk  input  1  system clock, rising edge; one clock domain.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  level; begins a forming run when sampled high in IDLE.
- abort  input  1  level; terminates the run.
- blk_sel  input  4  target block, latched at start.
- row_max  input  5  last row index to scan, latched at start.
- col_max  input  5  last column index to scan, latched at start.
- rram_data  input  1  verify read bit; 1 means the cell is formed.
- block_addr  output  4  current block.
- row_addr  output  5  current row.
- col_addr  output  5  current column.
- rram_ce  output  1  array enable, active-high.
- rram_we  output  1  forming pulse strobe, active-high.
- rram_re  output  1  verify read strobe, active-high.
- RB  output  1  ready/busy; 1 = ready (IDLE), 0 = busy.
- done  output  1  one-cycle pulse on run completion.
- fail_cnt  output  11  number of cells that failed in the last run.

Function
REQ-005 FSM states: IDLE, SETUP, PULSE, SETTLE, VERIFY, NEXT, DONE; all outputs registered.
REQ-006 IDLE: RB=1 and all strobes 0. start=1 latches blk_sel/row_max/col_max, clears the address, try count and fail_cnt, and moves to SETUP.
REQ-007 SETUP: 1 cycle with rram_ce=1 and the address stable, then PULSE.
REQ-008 PULSE: rram_ce=1 and rram_we=1 for exactly PULSE_W cycles, then SETTLE.
REQ-009 SETTLE: rram_ce=1 and we/re=0 for exactly SETTLE_W cycles, then VERIFY.
REQ-010 VERIFY: rram_ce=1 and rram_re=1 for 2 cycles; rram_data is sampled on the 2nd cycle.
REQ-011 Verify outcomes:
- rram_data=1: go to NEXT.
- rram_data=0 and try<MAX_TRY-1: increment try and return to PULSE, skipping SETUP.
- rram_data=0 and try=MAX_TRY-1: increment fail_cnt, then go to NEXT.
REQ-012 NEXT: 1 cycle with rram_ce=1.
- At row=row_max and col=col_max: go to DONE.
- Otherwise: col increments; when col=col_max, col wraps to 0 and row increments. Clear try and go to SETUP.
REQ-013 DONE: done=1 and rram_ce=0 for exactly 1 cycle, then IDLE. fail_cnt holds until the next start.
REQ-014 RB=0 in every state except IDLE. start in any non-IDLE state is ignored.
REQ-015 abort=1 in any non-IDLE state: next state is IDLE, all strobes drop on that edge, done is not pulsed, fail_cnt holds its partial value.
- abort and start both high in IDLE: abort wins and the FSM stays in IDLE.
REQ-016 rram_we and rram_re are never high in the same cycle; no strobe is high while rram_ce=0.
REQ-017 fail_cnt saturates at 2047 (not reachable with 32x32 cells, but required).
REQ-018 Cycle cost per cell: 10 cycles on a first-try pass; each retry adds PULSE_W+SETTLE_W+2 cycles.

Reset
REQ-019 rst=1 immediately forces IDLE, regardless of clk.
REQ-020 Output values while rst=1: block_addr=0, row_addr=0, col_addr=0, rram_ce=0, rram_we=0, rram_re=0, RB=1, done=0, fail_cnt=0, try=0.
REQ-021 rst asserted mid-run: strobes drop within the same cycle, and there is no done pulse after release.

Verification
REQ-022 Default parameters, row_max=0, col_max=1, rram_data tied 1, start sampled at edge 0 -> cells (0,0) and (0,1) are each 10 cycles with 4-cycle we pulses; done at cycle 21; fail_cnt=0; RB=1 at cycle 22.
REQ-023 row_max=0, col_max=0, rram_data=0 on the first two verifies and 1 on the third -> 3 we pulses, no SETUP between them; done at cycle 27; fail_cnt=0.
REQ-024 row_max=1, col_max=1, rram_data tied 0 -> 3 pulses per cell; address order (0,0),(0,1),(1,0),(1,1); fail_cnt=4; done exactly once.
REQ-025 Full array (row_max=31, col_max=31), rram_data=1 -> done at cycle 10241 with final address (31,31); a start pulse at cycle 500 is ignored.
REQ-026 abort raised during the 2nd PULSE cycle of cell (0,1) -> IDLE on the next edge; we=0 and RB=1 there; no done; fail_cnt unchanged. An async rst mid-SETTLE gives the REQ-020 values before the next clk edge.
